// File: rtl/gate_bias_adder.sv
// gate_bias_adder
//   Adds a per-element bias word to a stream of signed MAC dot-products and
//   saturates the result back to DATA_WIDTH. Elements are indexed 0..HIDDEN_SIZE-1.
//   Each element goes through IDLE -> FETCH -> OUT:
//     IDLE  : accept one input and issue a bias read.
//     FETCH : the bias word arrives and the sum is registered.
//     OUT   : hold the result until downstream takes it.
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   start                       pulse: the next element accepted uses index 0
//   in_valid / in_ready / in_data       dot-product input handshake
//   bias_read_enable / bias_pointer     bias memory read port (1-cycle registered read)
//   bias_element                bias word, valid the cycle after the read strobe
//   out_valid / out_ready       output handshake
//   out_data / out_index / out_last     saturated sum, its element index, last-element flag
module gate_bias_adder #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 7,
  parameter int HIDDEN_SIZE = 100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  bias_read_enable,
  output logic [ADDR_WIDTH-1:0] bias_pointer,
  input  logic [DATA_WIDTH-1:0] bias_element,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_index,
  output logic                  out_last
);

  typedef enum logic [1:0] {IDLE, FETCH, OUT} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(HIDDEN_SIZE - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] index_q, index_d;
  // A start seen while an element is in flight; applied when that element leaves.
  logic                  restart_q, restart_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [ADDR_WIDTH-1:0] out_index_q, out_index_d;
  logic                  out_last_q, out_last_d;

  logic                  accept;
  logic signed [DATA_WIDTH:0] sum;
  logic [DATA_WIDTH-1:0] sat;

  assign in_ready         = (state_q == IDLE);
  assign accept           = in_valid & in_ready;
  assign bias_read_enable = accept & ~rst;
  // A start arriving together with an accept must already address bias[0].
  assign bias_pointer     = (in_ready && start) ? '0 : index_q;

  assign out_valid = (state_q == OUT);
  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign out_last  = out_last_q;

  // One extra bit makes overflow visible as a mismatch of the top two bits.
  assign sum = $signed({din_q[DATA_WIDTH-1], din_q}) +
               $signed({bias_element[DATA_WIDTH-1], bias_element});

  always_comb begin
    sat = sum[DATA_WIDTH-1:0];
    if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1])
      sat = sum[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                            : {1'b0, {(DATA_WIDTH-1){1'b1}}};
  end

  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    restart_d   = restart_q;
    din_d       = din_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    out_last_d  = out_last_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          index_d   = '0;
          restart_d = 1'b0;
        end
        if (accept) begin
          din_d   = in_data;
          state_d = FETCH;
        end
      end
      FETCH: begin
        out_data_d  = sat;
        out_index_d = index_q;
        out_last_d  = (index_q == LAST_IDX);
        if (start) restart_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (start) restart_d = 1'b1;
        if (out_ready) begin
          state_d   = IDLE;
          restart_d = 1'b0;
          if (restart_q || start || index_q == LAST_IDX) index_d = '0;
          else                                          index_d = index_q + ADDR_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      index_q     <= '0;
      restart_q   <= 1'b0;
      din_q       <= '0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      restart_q   <= restart_d;
      din_q       <= din_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      out_last_q  <= out_last_d;
    end
  end

endmodule

// File: tb/tb_gate_bias_adder.sv
module tb_gate_bias_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        bias_read_enable;
  logic [6:0]  bias_pointer;
  logic [15:0] bias_element;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic [6:0]  out_index;
  logic        out_last;

  gate_bias_adder #(.DATA_WIDTH(16), .ADDR_WIDTH(7), .HIDDEN_SIZE(100)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .bias_read_enable(bias_read_enable), .bias_pointer(bias_pointer),
    .bias_element(bias_element), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // bias memory with a 1-cycle registered read
  logic [15:0] mem [128];
  logic [15:0] bias_q = '0;
  assign bias_element = bias_q;
  always @(posedge clk) if (bias_read_enable) bias_q <= mem[bias_pointer];

  int n_chk = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return 16'(s);
  endfunction

  // transaction-level reference: one element in flight, edges since its accept
  bit          m_busy = 0;
  int          m_age = 0;
  int          m_idx = 0;
  bit          m_restart = 0;
  logic [15:0] e_d = '0;
  int          e_i = 0;
  bit          e_l = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_idx = 0; m_restart = 0; m_age = 0;
    end else if (!m_busy) begin
      if (start) m_idx = 0;
      if (in_valid) begin
        e_d = sat_add(in_data, mem[m_idx]);
        e_i = m_idx;
        e_l = (m_idx == 99);
        m_busy = 1; m_age = 1;
      end
    end else if (m_age >= 2 && out_ready) begin
      m_busy = 0;
      m_idx = (m_restart || start || m_idx == 99) ? 0 : m_idx + 1;
      m_restart = 0;
    end else begin
      if (start) m_restart = 1;
      m_age++;
    end
  end

  // compare process
  always @(negedge clk) if (mon_en) begin
    if (rst) begin
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_bre", bias_read_enable, 0);
    end else begin
      chk("in_ready", in_ready, !m_busy);
      chk("out_valid", out_valid, m_busy && m_age >= 2);
      chk("bre", bias_read_enable, in_valid && !m_busy);
      if (!m_busy) chk("bias_pointer", bias_pointer, start ? 0 : m_idx);
      if (m_busy && m_age >= 2) begin
        chk("out_data", out_data, e_d);
        chk("out_index", out_index, e_i);
        chk("out_last", out_last, e_l);
      end
    end
  end

  // One element: accept on the next edge, then random in_valid noise while
  // busy, out_ready held low `hold` cycles after out_valid. Negative exp_* skip.
  task automatic do_elem(input logic [15:0] din, input bit st, input int hold,
                         input int exp_ptr, input int exp_d, input int exp_i, input int exp_l);
    bit seen;
    in_valid = 1; in_data = din; start = st;
    #1;
    if (exp_ptr >= 0) chk("accept_ptr", bias_pointer, exp_ptr);
    @(posedge clk); #1;
    in_valid = 0; start = 0;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
      else begin in_valid = $urandom_range(0, 1); in_data = 16'($urandom); end
    end
    if (!seen) chk("out_valid_timeout", 0, 1);
    if (exp_d >= 0) chk("lit_out_data", out_data, exp_d);
    if (exp_i >= 0) chk("lit_out_index", out_index, exp_i);
    if (exp_l >= 0) chk("lit_out_last", out_last, exp_l);
    for (int c = 0; c < hold; c++) begin
      in_valid = $urandom_range(0, 1); in_data = 16'($urandom);
      @(negedge clk);
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);
    mem[3] = 16'h0100; mem[4] = 16'h0200; mem[5] = 16'hFE00;

    // reset values, with in_valid asserted to show the read strobe is masked
    in_valid = 1; in_data = 16'h1234;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_out_index", out_index, 0);
    chk("reset_out_last", out_last, 0);
    chk("reset_bre", bias_read_enable, 0);
    chk("reset_ptr", bias_pointer, 0);
    @(posedge clk); #1;
    in_valid = 0; rst = 0; mon_en = 1;

    // three random elements, then the 0x0200 + 0x0100 case at index 3
    do_elem(16'($urandom), 1, 0, 0, -1, 0, 0);
    do_elem(16'($urandom), 0, 1, 1, -1, 1, -1);
    do_elem(16'($urandom), 0, 0, 2, -1, 2, -1);
    do_elem(16'h0200, 0, 0, 3, 16'h0300, 3, 0);
    // saturation both ways; the second one stalls 5 cycles with noise
    do_elem(16'h7F00, 0, 0, 4, 16'h7FFF, 4, -1);
    do_elem(16'h8100, 0, 5, 5, 16'h8000, 5, -1);

    // stream to the end of the timestep and wrap
    while (m_idx != 99) do_elem(16'($urandom), 0, $urandom_range(0, 2), -1, -1, -1, -1);
    do_elem(16'($urandom), 0, 0, 99, -1, 99, 1);
    do_elem(16'($urandom), 0, 0, 0, -1, 0, 0);

    // start coincident with an accept at index 42
    while (m_idx != 42) do_elem(16'($urandom), 0, $urandom_range(0, 1), -1, -1, -1, -1);
    do_elem(16'h0001, 1, 0, 0, -1, 0, -1);

    // start while an element is in OUT: that element keeps its index
    do_elem(16'($urandom), 0, 0, 1, -1, -1, -1);
    in_valid = 1; in_data = 16'h0055;
    @(posedge clk); #1; in_valid = 0;
    @(posedge clk); #1; start = 1;
    @(posedge clk); #1; start = 0;
    chk("start_in_out_index", out_index, 2);
    out_ready = 1;
    @(posedge clk); #1; out_ready = 0;
    do_elem(16'($urandom), 0, 0, 0, -1, 0, -1);

    // reset while in FETCH discards the element
    in_valid = 1; in_data = 16'h4444;
    @(posedge clk); #1;
    in_valid = 0; rst = 1; out_ready = 1;
    #1;
    chk("rst_fetch_in_ready", in_ready, 1);
    chk("rst_fetch_out_valid", out_valid, 0);
    @(posedge clk); #1;
    rst = 0;
    repeat (3) @(posedge clk);
    #1; out_ready = 0;
    do_elem(16'($urandom), 0, 0, 0, -1, 0, 0);

    // random tail
    for (int k = 0; k < 30; k++)
      do_elem(16'($urandom), ($urandom_range(0, 9) == 0), $urandom_range(0, 3), -1, -1, -1, -1);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
